// File: rtl/vga_rx_monitor.sv
// VGA receive monitor: recovers pixel coordinates, measures frame geometry and per-frame CRC.
// Optional define VGA_RX_CRC_EN enables the CRC-16-CCITT datapath; without it frame_crc is 0.
module vga_rx_monitor #(
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        vga_hsync,
  input  logic        vga_vsync,
  input  logic        vga_de,
  input  logic [15:0] vga_rgb,
  output logic        pix_valid,
  output logic [15:0] pix_x,
  output logic [15:0] pix_y,
  output logic [15:0] pix_rgb,
  output logic        frame_done,
  output logic [15:0] frame_width,
  output logic [15:0] frame_height,
  output logic [15:0] line_total,
  output logic [15:0] frame_crc,
  output logic        err_width,
  output logic        locked
);

  // state     | meaning
  // ST_IDLE   | no SOF seen since reset; the next SOF only arms measurement
  // ST_ARMED  | measuring; every SOF publishes the frame just finished
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_frame_end;

  logic        r_hs_d;
  logic        r_vs_d;
  logic        r_de_d;
  logic        w_hs_edge;
  logic        w_sof;
  logic        w_de_fall;
  logic        w_geom_match;

  logic [15:0] r_x_cnt;
  logic [15:0] r_y_cnt;
  logic [15:0] r_h_cnt;
  logic [15:0] r_ref_width;
  logic        r_err_acc;
  logic        r_line_seen;
  logic        r_have_prev;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_hs_edge    = (vga_hsync == HS_POL) && (r_hs_d != HS_POL);
  assign w_sof        = (vga_vsync == VS_POL) && (r_vs_d != VS_POL);
  assign w_de_fall    = r_de_d && !vga_de;
  assign w_geom_match = (r_ref_width == frame_width) && (r_y_cnt == frame_height);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_frame_end = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_sof) w_state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (w_sof) w_frame_end = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hs_d <= 1'b0;
      r_vs_d <= 1'b0;
      r_de_d <= 1'b0;
    end else begin
      r_hs_d <= vga_hsync;
      r_vs_d <= vga_vsync;
      r_de_d <= vga_de;
    end
  end

  // A pixel on the SOF cycle is coordinate (0,0) of the new frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pix_valid <= 1'b0;
      pix_x     <= 16'd0;
      pix_y     <= 16'd0;
      pix_rgb   <= 16'd0;
    end else begin
      pix_valid <= vga_de;
      if (vga_de) begin
        pix_rgb <= vga_rgb;
        pix_x   <= w_sof ? 16'd0 : r_x_cnt;
        pix_y   <= w_sof ? 16'd0 : r_y_cnt;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_x_cnt     <= 16'd0;
      r_y_cnt     <= 16'd0;
      r_ref_width <= 16'd0;
      r_err_acc   <= 1'b0;
      r_line_seen <= 1'b0;
    end else if (w_sof) begin
      r_x_cnt     <= vga_de ? 16'd1 : 16'd0;
      r_y_cnt     <= 16'd0;
      r_err_acc   <= 1'b0;
      r_line_seen <= 1'b0;
    end else if (vga_de) begin
      r_x_cnt <= sat_inc(r_x_cnt);
    end else if (w_de_fall) begin
      r_x_cnt <= 16'd0;
      r_y_cnt <= sat_inc(r_y_cnt);
      if (!r_line_seen) begin
        r_ref_width <= r_x_cnt;
        r_line_seen <= 1'b1;
      end else if (r_x_cnt != r_ref_width) begin
        r_err_acc <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_h_cnt    <= 16'd0;
      line_total <= 16'd0;
    end else if (w_hs_edge) begin
      line_total <= r_h_cnt;
      r_h_cnt    <= 16'd1;
    end else begin
      r_h_cnt <= sat_inc(r_h_cnt);
    end
  end

  // Lock needs two consecutive error-free frames with identical geometry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_done   <= 1'b0;
      frame_width  <= 16'd0;
      frame_height <= 16'd0;
      err_width    <= 1'b0;
      locked       <= 1'b0;
      r_have_prev  <= 1'b0;
    end else begin
      frame_done <= w_frame_end;
      if (w_frame_end) begin
        frame_width  <= r_ref_width;
        frame_height <= r_y_cnt;
        err_width    <= r_err_acc;
        locked       <= r_have_prev && !r_err_acc && !err_width && w_geom_match;
        r_have_prev  <= 1'b1;
      end
    end
  end

`ifdef VGA_RX_CRC_EN
  logic [15:0] r_crc;
  logic [15:0] w_crc_base;

  function automatic logic [15:0] crc_fold(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] v;
    v = c;
    for (int i = 15; i >= 0; i--) begin
      v = {v[14:0], 1'b0} ^ ((v[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    end
    return v;
  endfunction

  assign w_crc_base = w_sof ? 16'hFFFF : r_crc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_crc     <= 16'hFFFF;
      frame_crc <= 16'd0;
    end else begin
      if (vga_de) begin
        r_crc <= crc_fold(w_crc_base, vga_rgb);
      end else begin
        r_crc <= w_crc_base;
      end
      if (w_frame_end) frame_crc <= r_crc;
    end
  end
`else
  assign frame_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor: table of frames with expected results, plus reset and SOF corner sequences.
module tb_vga_rx_monitor;
  logic        clk = 1'b0;
  logic        rstn;
  logic        vga_hsync, vga_vsync, vga_de;
  logic [15:0] vga_rgb;
  logic        pix_valid, frame_done, err_width, locked;
  logic [15:0] pix_x, pix_y, pix_rgb, frame_width, frame_height, line_total, frame_crc;

  int total = 0;
  int bad = 0;

  logic        s_done, s_err, s_lock;
  logic [15:0] s_w, s_h, s_lt, s_crc;
  logic [15:0] last_crc = 16'hFFFF;
  logic [15:0] last_rgb = 16'h0000;
  logic [15:0] crc_exp;

  typedef struct {
    int          bad_line;
    bit          exp_done;
    logic [15:0] exp_w;
    logic [15:0] exp_h;
    bit          exp_err;
    bit          exp_lock;
  } vec_t;
  vec_t vecs[7];

  vga_rx_monitor #(.HS_POL(1'b0), .VS_POL(1'b0)) dut (
    .clk(clk), .rstn(rstn),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_de(vga_de), .vga_rgb(vga_rgb),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .frame_done(frame_done), .frame_width(frame_width), .frame_height(frame_height),
    .line_total(line_total), .frame_crc(frame_crc), .err_width(err_width), .locked(locked)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] m_fold(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = (r << 1) ^ 16'h1021;
      else r = r << 1;
    end
    return r;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pix_valid"}, pix_valid, 0);
    chk({tag, "_pix_x"}, pix_x, 0);
    chk({tag, "_pix_y"}, pix_y, 0);
    chk({tag, "_pix_rgb"}, pix_rgb, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_frame_width"}, frame_width, 0);
    chk({tag, "_frame_height"}, frame_height, 0);
    chk({tag, "_line_total"}, line_total, 0);
    chk({tag, "_frame_crc"}, frame_crc, 0);
    chk({tag, "_err_width"}, err_width, 0);
    chk({tag, "_locked"}, locked, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      vga_hsync = 1'b1; vga_vsync = 1'b1; vga_de = 1'b0; vga_rgb = 16'($urandom);
      step();
    end
  endtask

  // Lines are 12 clocks: hsync active for clocks 0-1, pixels from clock 3.
  // Line 0 carries vsync, lines 1..n_act are active, one blank line follows.
  task automatic send_frame(input int n_act, input int n_px, input int bad_line, input bit zero_px);
    logic [15:0] m_crc;
    logic [15:0] px;
    bit          de_now;
    int          w;
    int          al;
    m_crc = 16'hFFFF;
    for (int l = 0; l < n_act + 2; l++) begin
      for (int c = 0; c < 12; c++) begin
        al = l - 1;
        w = (al == bad_line) ? n_px - 1 : n_px;
        de_now = (l >= 1) && (l <= n_act) && (c >= 3) && (c < 3 + w);
        if (zero_px) px = 16'h0000;
        else if (al == 1 && c == 5) px = 16'hF81F;
        else px = 16'(al * 40 + c * 7 + 257);
        vga_hsync = (c < 2) ? 1'b0 : 1'b1;
        vga_vsync = (l == 0) ? 1'b0 : 1'b1;
        vga_de    = de_now;
        vga_rgb   = de_now ? px : 16'($urandom);
        if (de_now) m_crc = m_fold(m_crc, px);
        step();
        if (l == 0 && c == 0) begin
          s_done = frame_done; s_w = frame_width; s_h = frame_height; s_lt = line_total;
          s_crc = frame_crc; s_err = err_width; s_lock = locked;
        end
        if (l == 0 && c == 1) chk("done_one_cycle", frame_done, 0);
        chk("pix_valid", pix_valid, de_now);
        if (de_now) begin
          chk("pix_x", pix_x, 16'(c - 3));
          chk("pix_y", pix_y, 16'(al));
          chk("pix_rgb", pix_rgb, px);
          last_rgb = px;
        end else begin
          chk("pix_rgb_hold", pix_rgb, last_rgb);
        end
      end
    end
    last_crc = m_crc;
  endtask

  function automatic logic [15:0] crc_expect(input logic [15:0] model);
`ifdef VGA_RX_CRC_EN
    return model;
`else
    return (model == model) ? 16'h0000 : 16'h0000;
`endif
  endfunction

  initial begin
    vecs[0] = '{bad_line: -1, exp_done: 0, exp_w: 16'd0, exp_h: 16'd0, exp_err: 0, exp_lock: 0};
    vecs[1] = '{bad_line: -1, exp_done: 1, exp_w: 16'd8, exp_h: 16'd4, exp_err: 0, exp_lock: 0};
    vecs[2] = '{bad_line: -1, exp_done: 1, exp_w: 16'd8, exp_h: 16'd4, exp_err: 0, exp_lock: 1};
    vecs[3] = '{bad_line:  1, exp_done: 1, exp_w: 16'd8, exp_h: 16'd4, exp_err: 0, exp_lock: 1};
    vecs[4] = '{bad_line: -1, exp_done: 1, exp_w: 16'd8, exp_h: 16'd4, exp_err: 1, exp_lock: 0};
    vecs[5] = '{bad_line: -1, exp_done: 1, exp_w: 16'd8, exp_h: 16'd4, exp_err: 0, exp_lock: 0};
    vecs[6] = '{bad_line: -1, exp_done: 1, exp_w: 16'd8, exp_h: 16'd4, exp_err: 0, exp_lock: 1};

    rstn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vga_hsync = 1'($urandom); vga_vsync = 1'($urandom);
      vga_de = 1'($urandom); vga_rgb = 16'($urandom);
      step();
    end
    chk_all_zero("rst");
    vga_hsync = 1'b1; vga_vsync = 1'b1; vga_de = 1'b0;
    rstn = 1'b1;
    idle(3);

    for (int k = 0; k < 7; k++) begin
      crc_exp = crc_expect(last_crc);
      send_frame(4, 8, vecs[k].bad_line, 1'b0);
      chk($sformatf("v%0d_done", k), s_done, vecs[k].exp_done);
      chk($sformatf("v%0d_width", k), s_w, vecs[k].exp_w);
      chk($sformatf("v%0d_height", k), s_h, vecs[k].exp_h);
      chk($sformatf("v%0d_err", k), s_err, vecs[k].exp_err);
      chk($sformatf("v%0d_locked", k), s_lock, vecs[k].exp_lock);
      if (vecs[k].exp_done) begin
        chk($sformatf("v%0d_line_total", k), s_lt, 16'd12);
        chk($sformatf("v%0d_crc", k), s_crc, crc_exp);
      end
    end

    // Single black pixel frame; its results appear at the SOF below.
    send_frame(1, 1, -1, 1'b1);
    chk("crcf_sof_done", s_done, 1);
    chk("crcf_sof_locked", s_lock, 1);

    // SOF coinciding with an active pixel.
    vga_hsync = 1'b0; vga_vsync = 1'b0; vga_de = 1'b1; vga_rgb = 16'h1234;
    step();
    chk("sofde_done", frame_done, 1);
    chk("sofde_width", frame_width, 16'd1);
    chk("sofde_height", frame_height, 16'd1);
`ifdef VGA_RX_CRC_EN
    chk("sofde_crc", frame_crc, 16'h1D0F);
`else
    chk("sofde_crc", frame_crc, 16'h0000);
`endif
    chk("sofde_err", err_width, 0);
    chk("sofde_locked", locked, 0);
    chk("sofde_pix_valid", pix_valid, 1);
    chk("sofde_pix_x", pix_x, 16'd0);
    chk("sofde_pix_y", pix_y, 16'd0);
    chk("sofde_pix_rgb", pix_rgb, 16'h1234);
    vga_rgb = 16'hABCD;
    step();
    chk("sofde_next_x", pix_x, 16'd1);
    chk("sofde_next_y", pix_y, 16'd0);
    chk("sofde_next_done", frame_done, 0);
    vga_hsync = 1'b1; vga_de = 1'b0;
    step();
    chk("sofde_de_off", pix_valid, 0);
    vga_de = 1'b1; vga_rgb = 16'h5555;
    step();

    // Reset in the middle of a frame.
    rstn = 1'b0;
    #1;
    chk_all_zero("midrst");
    step();
    vga_hsync = 1'b1; vga_vsync = 1'b1; vga_de = 1'b0;
    rstn = 1'b1;
    last_rgb = 16'h0000;
    idle(2);
    send_frame(4, 8, -1, 1'b0);
    chk("midrst_rearm_done", s_done, 0);
    crc_exp = crc_expect(last_crc);
    send_frame(4, 8, -1, 1'b0);
    chk("midrst_done", s_done, 1);
    chk("midrst_width", s_w, 16'd8);
    chk("midrst_height", s_h, 16'd4);
    chk("midrst_line_total", s_lt, 16'd12);
    chk("midrst_crc", s_crc, crc_exp);
    chk("midrst_locked", s_lock, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_rx_monitor.md
# vga_rx_monitor

Receive-side counterpart of the VGA output stage. Samples the registered VGA stream (hsync, vsync, data enable, RGB565) on the pixel clock, recovers per-pixel coordinates, and measures frame geometry. Produces a per-frame CRC over all active pixels. Used in simulation benches and as an on-chip self-check tapped onto the top-level VGA pins; it never drives the display.

## Interface
Parameters:
- HS_POL, 0, hsync active level (0 = active-low, 1 = active-high)
- VS_POL, 0, vsync active level (0 = active-low, 1 = active-high)

Ports:
- clk  input  1  pixel clock, same clock that launches the VGA outputs
- rstn  input  1  reset, asynchronous, active-low
- vga_hsync  input  1  horizontal sync
- vga_vsync  input  1  vertical sync
- vga_de  input  1  data enable
- vga_rgb  input  16  RGB565 pixel
- pix_valid  output  1  registered copy of vga_de
- pix_x  output  16  column of current active pixel
- pix_y  output  16  row of current active pixel
- pix_rgb  output  16  registered copy of vga_rgb
- frame_done  output  1  one-cycle pulse: frame results updated
- frame_width  output  16  active pixels per line, first line of last frame
- frame_height  output  16  active lines in last frame
- line_total  output  16  clocks between last two hsync active edges
- frame_crc  output  16  CRC of last frame's active pixels
- err_width  output  1  last frame had a line width differing from its first line
- locked  output  1  geometry stable across consecutive frames

## Operation
- Input history: previous hsync/vsync/de are held in registers. An active edge is the transition from inactive level to active level, per HS_POL/VS_POL.
- SOF: vsync active edge.
- Pixel path, for each cycle with de=1:
  - pix_valid<=1, pix_rgb<=vga_rgb, pix_x<=x_cnt, pix_y<=y_cnt.
  - x_cnt increments.
  - CRC folds in vga_rgb.
- Pixel path, for each cycle with de=0: pix_valid<=0; pix_x, pix_y and pix_rgb hold.
- End of active line (de falling edge):
  - y_cnt increments and x_cnt clears.
  - If this is the first line of the frame, its width becomes ref_width.
  - Otherwise, a width different from ref_width sets err_acc.
- Line period:
  - h_cnt counts clocks.
  - On each hsync active edge: line_total<=h_cnt, then h_cnt<=1.
- At each SOF after the first SOF since reset:
  - frame_width<=ref_width, frame_height<=y_cnt, frame_crc<=crc, err_width<=err_acc.
  - frame_done pulses.
  - locked<=1 only if err_acc=0 and (ref_width, y_cnt) equals the previous frame's (frame_width, frame_height) with the previous frame also error-free. Otherwise locked<=0.
- At every SOF: x_cnt, y_cnt, err_acc and the first-line flag clear, and crc<=16'hFFFF.
- First SOF after reset: arms measurement only. No frame_done.
- Counters (x_cnt, y_cnt, h_cnt) saturate at 16'hFFFF; they do not wrap.
- CRC-16-CCITT: poly 0x1021, init 0xFFFF, no reflection, no final XOR. Each 16-bit word is processed MSB first, 16 bit-steps unrolled per cycle.

## Timing
- Reset values: every output 0, all internal counters 0, crc 16'hFFFF, SOF-armed flag 0.
- Pixel outputs lag their inputs by 1 clock.
- frame_done and the frame result registers update on the clock edge that samples the SOF.
- Simultaneous SOF and de=1:
  - SOF clears the counters and CRC first.
  - The pixel is then counted as (0,0) of the new frame, and CRC = fold(0xFFFF, pixel).
  - The results latched in that cycle use pre-clear values.
- A de falling edge coinciding with an hsync active edge: both are processed independently in the same cycle.
- Reset asserted mid-frame: everything returns to reset values immediately. The next SOF only re-arms.
- No backpressure; the block accepts one pixel per clock indefinitely.

## Configuration
- VGA_RX_CRC_EN defined: the CRC datapath is present and frame_crc is as specified.
- Not defined: the CRC logic is removed and frame_crc is constant 0. All other behaviour is unchanged.

## Test plan
- Reset: hold rstn=0 with random inputs → all outputs 0. After release, the first SOF gives no frame_done.
- Clean geometry: frames of 12-clock lines (8 active) and 6-line frames (4 active), active-low syncs.
  - Second SOF → frame_done with width 8, height 4, line_total 12, err_width 0, locked 0.
  - Third SOF → locked 1.
- CRC (macro defined): frame with one active pixel 0x0000 → frame_crc 0x1D0F. Macro undefined → 0.
- Width error: second line carries 7 active pixels → err_width 1 and locked 0 at that frame's done. The next clean frame → err_width 0 and locked 0. The frame after that → locked 1.
- Coordinates: third pixel of the second active line, rgb 0xF81F → one clock later pix_valid 1, pix_x 2, pix_y 1, pix_rgb 0xF81F.
- Simultaneous/reset: de=1 on the SOF cycle → that pixel reported at (0,0). Reset pulsed mid-frame → the next SOF produces no frame_done and the one after does.
